// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line walker emitting one pixel per valid/ready handshake.
// Define LINE_RASTER_ADDR_EN to add a registered y*H_PIXELS+x framebuffer address.
module line_rasterizer #(
  parameter logic [23:0] COLOR    = 24'hFF_FF_FF,
  parameter int          H_PIXELS = 1280
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x1_in,
  input  logic [10:0] x2_in,
  input  logic [9:0]  y1_in,
  input  logic [9:0]  y2_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  output logic [10:0] pixel_x_out,
  output logic [9:0]  pixel_y_out,
  output logic [23:0] pixel_color_out,
  output logic [19:0] pixel_addr_out,
  output logic        pixel_valid_out,
  input  logic        pixel_ready_in,
  output logic        pixel_last_out,
  output logic        busy_out,
  output logic [1:0]  state_dbg_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [10:0]        x1_q, x1_d, x2_q, x2_d, x_q, x_d;
  logic [9:0]         y1_q, y1_d, y2_q, y2_d, y_q, y_d;
  logic signed [12:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [10:0]        adx;
  logic [9:0]         ady;
  logic signed [13:0] e2, dx_ext, dy_ext;
  logic               at_end;

  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds its payload until then.
  assign cmd_ready_out   = (state_q == S_IDLE);
  assign busy_out        = (state_q != S_IDLE);
  assign pixel_valid_out = (state_q == S_DRAW);
  assign at_end          = (x_q == x2_q) && (y_q == y2_q);
  assign pixel_last_out  = pixel_valid_out && at_end;
  assign pixel_color_out = pixel_valid_out ? COLOR : 24'd0;
  assign pixel_x_out     = x_q;
  assign pixel_y_out     = y_q;
  assign state_dbg_out   = state_q;

  assign adx    = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
  assign ady    = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);
  assign e2     = {err_q, 1'b0};
  assign dx_ext = {dx_q[12], dx_q};
  assign dy_ext = {dy_q[12], dy_q};

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          x1_d    = x1_in;
          y1_d    = y1_in;
          x2_d    = x2_in;
          y2_d    = y2_in;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d     = $signed({2'b00, adx});
        dy_d     = 13'sd0 - $signed({3'b000, ady});
        err_d    = $signed({2'b00, adx}) - $signed({3'b000, ady});
        sx_neg_d = (x2_q < x1_q);
        sy_neg_d = (y2_q < y1_q);
        x_d      = x1_q;
        y_d      = y1_q;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (pixel_ready_in) begin
          if (at_end) begin
            state_d = S_IDLE;
          end else begin
            // Both tests use the pre-step e2, so a diagonal step updates x and y together.
            if (e2 >= dy_ext) begin
              err_d = err_d + dy_q;
              x_d   = sx_neg_q ? (x_q - 11'd1) : (x_q + 11'd1);
            end
            if (e2 <= dx_ext) begin
              err_d = err_d + dx_q;
              y_d   = sy_neg_q ? (y_q - 10'd1) : (y_q + 10'd1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

`ifdef LINE_RASTER_ADDR_EN
  logic [19:0] addr_q, addr_d;

  // Computed from the next coordinates so the address lands together with x/y.
  assign addr_d         = 20'((32'(y_d) * H_PIXELS) + 32'(x_d));
  assign pixel_addr_out = addr_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end
`else
  // The stride only matters for the address path; this folds to a constant zero.
  assign pixel_addr_out = 20'(H_PIXELS) & 20'd0;
`endif

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: reset, octant walks, backpressure, point, mid-line reset.
// Expected address follows LINE_RASTER_ADDR_EN (y*1280+x when defined, else 0).
module tb_line_rasterizer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x1_in, x2_in;
  logic [9:0]  y1_in, y2_in;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [10:0] pixel_x_out;
  logic [9:0]  pixel_y_out;
  logic [23:0] pixel_color_out;
  logic [19:0] pixel_addr_out;
  logic        pixel_valid_out;
  logic        pixel_ready_in;
  logic        pixel_last_out;
  logic        busy_out;
  logic [1:0]  state_dbg_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Pixel record: {addr[19:0], x[10:0], y[9:0], last}
  logic [41:0] exp_q[$];
  logic [41:0] obs_q[$];

  line_rasterizer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .x1_in(x1_in), .x2_in(x2_in), .y1_in(y1_in), .y2_in(y2_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
    .pixel_color_out(pixel_color_out), .pixel_addr_out(pixel_addr_out),
    .pixel_valid_out(pixel_valid_out), .pixel_ready_in(pixel_ready_in),
    .pixel_last_out(pixel_last_out), .busy_out(busy_out),
    .state_dbg_out(state_dbg_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] exp_addr(input int x, input int y);
`ifdef LINE_RASTER_ADDR_EN
    return 20'(y * 1280 + x);
`else
    return 20'(y * 1280 + x) & 20'd0;
`endif
  endfunction

  function automatic logic [41:0] pix(input int x, input int y, input bit last);
    return {exp_addr(x, y), 11'(x), 10'(y), last};
  endfunction

  function automatic logic [41:0] cur_pix();
    return {pixel_addr_out, pixel_x_out, pixel_y_out, pixel_last_out};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Presents a command at #1 after an edge and returns #1 after the accepting edge.
  task automatic send_cmd(input int ax, input int ay, input int bx, input int by, output bit ok);
    x1_in = 11'(ax); y1_in = 10'(ay); x2_in = 11'(bx); y2_in = 10'(by);
    cmd_valid_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready_out) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid_in = 1'b0;
  endtask

  // Holds ready high and records every handshaken pixel until the last one.
  task automatic collect_line(input int budget, output int cycles, output bit done);
    obs_q.delete();
    pixel_ready_in = 1'b1;
    cycles = 0;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pixel_valid_out) begin
        obs_q.push_back(cur_pix());
        done = pixel_last_out;
      end
      tick();
      cycles++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    cmd_valid_in = 1'b0; pixel_ready_in = 1'b0;
    x1_in = '0; x2_in = '0; y1_in = '0; y2_in = '0;
    #3;
    n_checks++;
    if ({pixel_valid_out, pixel_last_out, busy_out, cmd_ready_out} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v/l/b/r=%b expected 0001",
               {pixel_valid_out, pixel_last_out, busy_out, cmd_ready_out});
    end
    n_checks++;
    if ({pixel_x_out, pixel_y_out, pixel_addr_out, pixel_color_out} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_data: got x=%0d y=%0d addr=%0d color=%h expected all 0",
               pixel_x_out, pixel_y_out, pixel_addr_out, pixel_color_out);
    end
    cmd_valid_in = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy_out !== 1'b0 || state_dbg_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got busy=%b state=%0d expected 0/0", busy_out, state_dbg_out);
    end
    cmd_valid_in = 1'b0;
    rst_in = 1'b1;
  endtask

  task automatic test_horizontal();
    int cycles;
    bit done;
    x1_in = 11'd10; y1_in = 10'd5; x2_in = 11'd14; y2_in = 10'd5;
    cmd_valid_in = 1'b1;
    tick();
    cmd_valid_in = 1'b0;
    n_checks++;
    if ({busy_out, cmd_ready_out, pixel_valid_out} !== 3'b100) begin
      n_fail++;
      $display("FAIL horiz_accept: got busy/ready/valid=%b expected 100",
               {busy_out, cmd_ready_out, pixel_valid_out});
    end
    tick();
    n_checks++;
    if (pixel_valid_out !== 1'b1 || pixel_color_out !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL horiz_latency: got valid=%b color=%h expected 1/ffffff",
               pixel_valid_out, pixel_color_out);
    end
    exp_q.delete();
    for (int x = 10; x <= 14; x++) exp_q.push_back(pix(x, 5, x == 14));
    collect_line(40, cycles, done);
    n_checks++;
    if (!done || cycles != 5 || obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL horiz_rate: got done=%b cycles=%0d pixels=%0d expected 1/5/5",
               done, cycles, obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL horiz_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    n_checks++;
    if ({cmd_ready_out, pixel_valid_out, pixel_color_out} !== {2'b10, 24'd0}) begin
      n_fail++;
      $display("FAIL horiz_idle: got ready=%b valid=%b color=%h expected 1/0/0",
               cmd_ready_out, pixel_valid_out, pixel_color_out);
    end
  endtask

  task automatic test_steep_reverse();
    int cycles;
    bit done, ok;
    send_cmd(3, 10, 1, 4, ok);
    // Competing command and new endpoints while busy must not disturb the line.
    x1_in = 11'd100; y1_in = 10'd100; x2_in = 11'd0; y2_in = 10'd0;
    cmd_valid_in = 1'b1;
    tick();
    exp_q.delete();
    exp_q.push_back(pix(3, 10, 0)); exp_q.push_back(pix(3, 9, 0));
    exp_q.push_back(pix(2, 8, 0));  exp_q.push_back(pix(2, 7, 0));
    exp_q.push_back(pix(2, 6, 0));  exp_q.push_back(pix(1, 5, 0));
    exp_q.push_back(pix(1, 4, 1));
    collect_line(40, cycles, done);
    cmd_valid_in = 1'b0;
    n_checks++;
    if (!ok || !done || obs_q.size() != 7) begin
      n_fail++;
      $display("FAIL steep_count: got ok=%b done=%b pixels=%0d expected 1/1/7", ok, done, obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL steep_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    tick();
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL steep_no_reaccept: got busy=%b expected 0", busy_out);
    end
  endtask

  task automatic test_backpressure();
    bit ok, done;
    int stall_cnt;
    logic [41:0] held;
    send_cmd(0, 0, 7, 3, ok);
    tick();
    exp_q.delete();
    exp_q.push_back(pix(0, 0, 0)); exp_q.push_back(pix(1, 0, 0));
    exp_q.push_back(pix(2, 1, 0)); exp_q.push_back(pix(3, 1, 0));
    exp_q.push_back(pix(4, 2, 0)); exp_q.push_back(pix(5, 2, 0));
    exp_q.push_back(pix(6, 3, 0)); exp_q.push_back(pix(7, 3, 1));
    obs_q.delete();
    stall_cnt = 0;
    done = 1'b0;
    held = '0;
    for (int i = 0; i < 60; i++) begin
      if (obs_q.size() == 3 && stall_cnt < 3) begin
        pixel_ready_in = 1'b0;
        if (stall_cnt == 0) begin
          held = cur_pix();
        end else begin
          n_checks++;
          if (cur_pix() !== held || pixel_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got %h valid=%b expected %h valid=1",
                     stall_cnt, cur_pix(), pixel_valid_out, held);
          end
        end
        stall_cnt++;
      end else begin
        pixel_ready_in = 1'b1;
        if (pixel_valid_out) begin
          obs_q.push_back(cur_pix());
          done = pixel_last_out;
        end
      end
      tick();
      if (done) break;
    end
    n_checks++;
    if (!ok || !done || stall_cnt != 3 || obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL stall_count: got ok=%b done=%b stalls=%0d pixels=%0d expected 1/1/3/8",
               ok, done, stall_cnt, obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_point();
    int cycles;
    bit done, ok;
    send_cmd(6, 6, 6, 6, ok);
    tick();
    collect_line(10, cycles, done);
    n_checks++;
    if (!ok || !done || cycles != 1 || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL point_count: got ok=%b done=%b cycles=%0d pixels=%0d expected 1/1/1/1",
               ok, done, cycles, obs_q.size());
    end
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0] !== pix(6, 6, 1)) begin
      n_fail++;
      $display("FAIL point_pix: got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 42'bx, pix(6, 6, 1));
    end
    n_checks++;
    if ({cmd_ready_out, pixel_valid_out, busy_out} !== 3'b100) begin
      n_fail++;
      $display("FAIL point_ready_next: got ready/valid/busy=%b expected 100",
               {cmd_ready_out, pixel_valid_out, busy_out});
    end
  endtask

  task automatic test_addr_point();
    int cycles;
    bit done, ok;
    send_cmd(5, 2, 5, 2, ok);
    tick();
    n_checks++;
    if (pixel_addr_out !== exp_addr(5, 2) || pixel_last_out !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_point: got addr=%0d last=%b expected %0d/1",
               pixel_addr_out, pixel_last_out, exp_addr(5, 2));
    end
    collect_line(10, cycles, done);
  endtask

  task automatic test_reset_midline();
    int cycles;
    bit done, ok;
    send_cmd(0, 0, 20, 0, ok);
    pixel_ready_in = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (pixel_valid_out !== 1'b1 || pixel_x_out !== 11'd2) begin
      n_fail++;
      $display("FAIL midrst_pre: got valid=%b x=%0d expected 1/2", pixel_valid_out, pixel_x_out);
    end
    #2 rst_in = 1'b0;
    #1;
    n_checks++;
    if ({pixel_valid_out, pixel_last_out, busy_out, cmd_ready_out} !== 4'b0001 ||
        {pixel_x_out, pixel_y_out, pixel_color_out} !== 45'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got v/l/b/r=%b x=%0d y=%0d color=%h expected 0001 and zeros",
               {pixel_valid_out, pixel_last_out, busy_out, cmd_ready_out},
               pixel_x_out, pixel_y_out, pixel_color_out);
    end
    x1_in = 11'd2; y1_in = 10'd3; x2_in = 11'd4; y2_in = 10'd3;
    cmd_valid_in = 1'b1;
    tick();
    rst_in = 1'b1;
    tick();
    cmd_valid_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b1 || pixel_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_accept: got busy=%b valid=%b expected 1/0", busy_out, pixel_valid_out);
    end
    tick();
    exp_q.delete();
    exp_q.push_back(pix(2, 3, 0)); exp_q.push_back(pix(3, 3, 0)); exp_q.push_back(pix(4, 3, 1));
    collect_line(20, cycles, done);
    n_checks++;
    if (!done || obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL midrst_count: got done=%b pixels=%0d expected 1/3", done, obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [41:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_pix%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep_reverse();
    test_backpressure();
    test_point();
    test_addr_point();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter COLOR, default 24'hFF_FF_FF: RGB value driven on pixel_color_out.
REQ-002 SHALL have parameter H_PIXELS, default 1280: framebuffer row stride used for address generation.
REQ-003 SHALL have port clk_in  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1: asynchronous, active-low reset.
REQ-005 SHALL have ports x1_in, x2_in  input  11 each: endpoint x coordinates.
REQ-006 SHALL have ports y1_in, y2_in  input  10 each: endpoint y coordinates.
REQ-007 SHALL have port cmd_valid_in  input  1: endpoints valid.
REQ-008 SHALL have port cmd_ready_out  output  1: command accepted when high with cmd_valid_in.
REQ-009 SHALL have ports pixel_x_out  output  11 and pixel_y_out  output  10: current pixel coordinate.
REQ-010 SHALL have port pixel_color_out  output  24: equals COLOR while pixel_valid_out is high, else 0.
REQ-011 SHALL have port pixel_addr_out  output  20: pixel_y_out*H_PIXELS+pixel_x_out (see Configuration).
REQ-012 SHALL have ports pixel_valid_out  output  1 and pixel_ready_in  input  1: pixel write handshake.
REQ-013 SHALL have port pixel_last_out  output  1: high with the final pixel of a line.
REQ-014 SHALL have port busy_out  output  1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> DRAW -> IDLE; cmd_ready_out = 1 only in IDLE.
REQ-016 SHALL latch all four endpoints on the cycle cmd_valid_in & cmd_ready_out; the FSM then enters SETUP.
REQ-017 In SETUP, SHALL compute dx=|x2-x1|, dy=-|y2-y1|, sx=±1, sy=±1, err=dx+dy (13-bit signed), x=x1, y=y1; the FSM then enters DRAW.
REQ-018 SHALL raise pixel_valid_out on the first DRAW cycle; accept-to-first-pixel latency = 2 cycles.
REQ-019 SHALL hold pixel_x/y/addr/last outputs stable while pixel_valid_out & !pixel_ready_in.
REQ-020 On each pixel handshake that is not the last, SHALL step by all-octant Bresenham on the same edge: e2=2*err.
REQ-020a If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates apply in one cycle when both hold.
REQ-021 SHALL sustain 1 pixel per cycle while pixel_ready_in is held high.
REQ-022 SHALL assert pixel_last_out exactly when x==x2 and y==y2; a line emits max(dx,|dy|)+1 pixels.
REQ-023 After the last-pixel handshake, SHALL deassert pixel_valid_out and return to IDLE; cmd_ready_out goes high the next cycle.
REQ-024 x1==x2 and y1==y2 SHALL produce exactly one pixel with pixel_last_out=1.
REQ-025 Pixel order SHALL run from (x1,y1) to (x2,y2) for every octant, including reversed and vertical lines.
REQ-026 cmd_valid_in SHALL be ignored outside IDLE; endpoint input changes after acceptance SHALL have no effect.
REQ-027 SHALL NOT clip coordinates; coordinate arithmetic wraps modulo port width.

Reset
REQ-028 rst_in low SHALL immediately force IDLE, abort any line, and set pixel_valid_out=0, pixel_last_out=0, busy_out=0.
REQ-029 rst_in low SHALL also set pixel_x_out=0, pixel_y_out=0, pixel_addr_out=0 and pixel_color_out=0; cmd_ready_out=1 while idle in or out of reset.
REQ-030 The first command SHALL be accepted on the first rising edge after rst_in deasserts.

Configuration
REQ-031 Macro LINE_RASTER_ADDR_EN: when defined, pixel_addr_out SHALL be a registered y*H_PIXELS+x, aligned with pixel_x/y_out, with no added latency.
REQ-031a When LINE_RASTER_ADDR_EN is undefined, pixel_addr_out SHALL be constant 0 and no multiplier or adder SHALL be synthesized.

Verification
REQ-032 Horizontal line (10,5)->(14,5), ready high -> 5 consecutive pixels x=10..14 at y=5; last on 5th; first pixel 2 cycles after accept.
REQ-033 Steep reverse line (3,10)->(1,4) -> 7 pixels, y 10 down to 4; first pixel (3,10); last pixel (1,4) with pixel_last_out=1.
REQ-034 Backpressure: hold pixel_ready_in low 3 cycles mid-line (0,0)->(7,3) -> outputs stable; pixel sequence unchanged versus the no-stall run.
REQ-035 Point (6,6)->(6,6) -> single pixel with last=1; cmd_ready_out high the cycle after the handshake.
REQ-036 rst_in low during pixel 3 of (0,0)->(20,0) -> pixel_valid_out=0 immediately, busy_out=0; a new command is accepted after release.
REQ-037 LINE_RASTER_ADDR_EN defined, H_PIXELS=1280, line (5,2)->(5,2) -> pixel_addr_out=2565; macro undefined -> pixel_addr_out=0.
